mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter W, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port op  input  2  00 multu, 01 mult, 10 divu, 11 div.
REQ-006 SHALL have port a  input  W  rs operand (register-file read port 1).
REQ-007 SHALL have port b  input  W  rt operand (register-file read port 2).
REQ-008 SHALL have port hi_we  input  1  mthi strobe.
REQ-009 SHALL have port lo_we  input  1  mtlo strobe.
REQ-010 SHALL have port wdata  input  W  mthi/mtlo data.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-013 SHALL have port hi  output  W  HI register (product high half / remainder).
REQ-014 SHALL have port lo  output  W  LO register (product low half / quotient).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE->RUN on start.
- RUN->DONE after W iterations.
- DONE->IDLE after one cycle.
- DONE->RUN if start is high in DONE.
REQ-016 SHALL accept start only when busy=0; start while busy is ignored with no effect.
REQ-017 SHALL latch a, b and op at the accepting edge; later changes on a, b or op SHALL NOT affect the result.
REQ-018 SHALL hold busy=1 for exactly W cycles, starting at the accepting edge.
REQ-019 SHALL load hi/lo at the edge leaving RUN and SHALL assert done for exactly that following cycle.
- hi/lo are valid W cycles after the accepting edge.
REQ-020 SHALL hold hi/lo stable at their previous values during RUN.
REQ-021 multu/mult: SHALL use iterative shift-add, one bit per cycle, producing the 2W-bit product in {hi,lo}.
REQ-022 divu/div: SHALL use iterative restoring division, one bit per cycle.
- lo = quotient, hi = remainder.
REQ-023 Divide by zero: SHALL give hi=a, lo=all-ones, for both signed and unsigned division.
REQ-024 Signed overflow (div of -2^(W-1) by -1): SHALL give lo=-2^(W-1), hi=0.
REQ-025 Signed ops: SHALL operate on magnitudes and then correct signs.
- Quotient truncates toward zero.
- Remainder takes the sign of the dividend.
REQ-026 hi_we/lo_we: SHALL write wdata to hi/lo at the next edge, only when busy=0; strobes while busy SHALL be ignored.
REQ-027 If start and hi_we/lo_we are both accepted on the same edge, start SHALL win and the write SHALL be dropped.
REQ-028 If hi_we and lo_we are both high and not suppressed, both registers SHALL take wdata.

Reset
REQ-029 rst SHALL override all inputs at the next rising edge: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
REQ-030 rst during RUN SHALL abort the operation: no done pulse and no hi/lo update.
REQ-031 The first start SHALL be accepted on the edge after rst deasserts.

Configuration
REQ-032 Macro MULTDIV_SIGNED_EN SHALL control signed-operation support.
- Defined: op[0] selects signed mult/div per REQ-023..025.
- Undefined: op[0] is ignored, all operations are unsigned, and the sign-correction logic is not built.

Verification
REQ-033 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 32 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 mult a=-3, b=7 (macro defined) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. With macro undefined -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-035 div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=100, b=0 -> hi=100, lo=0xFFFFFFFF.
REQ-036 Start divu 9/2, pulse start again at cycle 5 with different operands -> second start ignored; lo=4, hi=1; busy low at cycle 32.
REQ-037 Start mult, assert rst at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse. Then mthi wdata=0x1234 -> hi=0x1234.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit, one bit per cycle
// Optional signed support via `define MULTDIV_SIGNED_EN (op[0] selects signed when defined).
module mult_div_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(W + 1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          isDiv;
    logic          bZero;
    logic [W-1:0]  opB;
    logic [W-1:0]  accHi;
    logic [W-1:0]  accLo;
    logic [W-1:0]  aSave;

    logic [W-1:0]  aMag;
    logic [W-1:0]  bMag;

    logic          accept;
    logic [W:0]    mulSum;
    logic [W-1:0]  mulHi;
    logic [W-1:0]  mulLo;
    logic [W:0]    divShift;
    logic [W:0]    divDiff;
    logic          divFits;
    logic [W-1:0]  divHi;
    logic [W-1:0]  divLo;
    logic [W-1:0]  stepHi;
    logic [W-1:0]  stepLo;
    logic [W-1:0]  resHi;
    logic [W-1:0]  resLo;

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = start && (state != RUN);

`ifdef MULTDIV_SIGNED_EN
    logic          inNegA;
    logic          inNegB;
    logic          negA;
    logic          negB;
    logic          ovf;
    logic [2*W-1:0] prodNeg;

    assign inNegA = op[0] & a[W-1];
    assign inNegB = op[0] & b[W-1];
    assign aMag   = inNegA ? -a : a;
    assign bMag   = inNegB ? -b : b;
    assign prodNeg = -{stepHi, stepLo};
`else
    logic unusedOp0;

    assign unusedOp0 = op[0];
    assign aMag      = a;
    assign bMag      = b;
`endif

    // Shift-add: accLo holds the unconsumed multiplier bits, product shifts in from the top.
    assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : {(W+1){1'b0}});
    assign mulHi  = mulSum[W:1];
    assign mulLo  = {mulSum[0], accLo[W-1:1]};

    // Restoring division: remainder in accHi, dividend shifts out of accLo as quotient shifts in.
    // With a nonzero divisor the shifted remainder is below 2*opB, so bit W is a clean borrow.
    assign divShift = {accHi, accLo[W-1]};
    assign divDiff  = divShift - {1'b0, opB};
    assign divFits  = ~divDiff[W];
    assign divHi    = divFits ? divDiff[W-1:0] : divShift[W-1:0];
    assign divLo    = {accLo[W-2:0], divFits};

    assign stepHi = isDiv ? divHi : mulHi;
    assign stepLo = isDiv ? divLo : mulLo;

    always_comb begin
        resHi = stepHi;
        resLo = stepLo;
`ifdef MULTDIV_SIGNED_EN
        if (!isDiv && (negA ^ negB)) begin
            resHi = prodNeg[2*W-1:W];
            resLo = prodNeg[W-1:0];
        end
        if (isDiv) begin
            if (negA ^ negB) begin
                resLo = -stepLo;
            end
            if (negA) begin
                resHi = -stepHi;
            end
            if (ovf) begin
                resLo = {1'b1, {(W-1){1'b0}}};
                resHi = '0;
            end
        end
`endif
        if (isDiv && bZero) begin
            resHi = aSave;
            resLo = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            isDiv <= 1'b0;
            bZero <= 1'b0;
            opB   <= '0;
            accHi <= '0;
            accLo <= '0;
            aSave <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (count == CW'(W - 1)) begin
                        hi    <= resHi;
                        lo    <= resLo;
                        state <= DONE;
                    end else begin
                        accHi <= stepHi;
                        accLo <= stepLo;
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    if (start) begin
                        state <= RUN;
                        count <= '0;
                        isDiv <= op[1];
                        bZero <= (b == '0);
                        opB   <= bMag;
                        accHi <= '0;
                        accLo <= aMag;
                        aSave <= a;
                    end else begin
                        state <= IDLE;
                        if (hi_we) begin
                            hi <= wdata;
                        end
                        if (lo_we) begin
                            lo <= wdata;
                        end
                    end
                end
            endcase
        end
    end

`ifdef MULTDIV_SIGNED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            negA <= 1'b0;
            negB <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            negA <= inNegA;
            negB <= inNegB;
            ovf  <= op[0] && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
        end
    end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed vector bench for mult_div_unit
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks = 0;
    int errors = 0;

    int   cyc;
    int   busyCnt;
    logic stableOk;
    logic [W-1:0] prevHi;
    logic [W-1:0] prevLo;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eHi;
        logic [W-1:0] eLo;
    } vec_t;

    vec_t vecs [13];

    mult_div_unit #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a start at the current negedge, then move to cycle 0 and scramble inputs.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        prevHi = hi;
        prevLo = lo;
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        @(negedge clk);
        start  = 1'b0;
        op     = ~o;
        a      = ~x;
        b      = ~y;
        busyCnt  = busy ? 1 : 0;
        stableOk = (hi === prevHi) && (lo === prevLo);
    endtask

    // Advance until done (bounded); cyc is the cycle index of done, -1 on timeout.
    task automatic waitDone();
        cyc = -1;
        for (int i = 1; i <= W + 4; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
            if (busy) busyCnt++;
            if (hi !== prevHi || lo !== prevLo) stableOk = 1'b0;
        end
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
`ifdef MULTDIV_SIGNED_EN
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[10] = '{2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006};
        vecs[11] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
`else
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
        vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vecs[10] = '{2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000006};
        vecs[11] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000007, 32'h00000000};
`endif
        vecs[3]  = '{2'b10, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
        vecs[4]  = '{2'b10, 32'd9,        32'd2,        32'd1,        32'd4};
        vecs[5]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[7]  = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[8]  = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[9]  = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[12] = '{2'b10, 32'h00000000, 32'd5,        32'h00000000, 32'h00000000};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            issue(vecs[k].op, vecs[k].a, vecs[k].b);
            waitDone();
            check($sformatf("v%0d_latency", k), W'(cyc), W'(W));
            check($sformatf("v%0d_busy_cycles", k), W'(busyCnt), W'(W));
            check($sformatf("v%0d_hold", k), W'(stableOk), W'(1));
            check($sformatf("v%0d_hi", k), hi, vecs[k].eHi);
            check($sformatf("v%0d_lo", k), lo, vecs[k].eLo);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", k), W'(done), '0);
        end

        // Start while busy is ignored
        @(negedge clk);
        issue(2'b10, 32'd9, 32'd2);
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            if (c == 4) begin
                start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (c == W - 1) check("ign_busy31", W'(busy), W'(1));
            if (c == W) begin
                check("ign_busy32", W'(busy), '0);
                check("ign_done32", W'(done), W'(1));
                check("ign_lo", lo, 32'd4);
                check("ign_hi", hi, 32'd1);
            end
        end
        @(negedge clk);
        check("ign_no_restart", W'(busy), '0);

        // Reset mid-run aborts, then mthi/mtlo
        issue(2'b01, 32'd5, 32'd6);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", W'(busy), '0);
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        begin
            logic sawDone;
            sawDone = 1'b0;
            for (int i = 0; i < W + 4; i++) begin
                @(negedge clk);
                if (done) sawDone = 1'b1;
            end
            check("abort_no_done", W'(sawDone), '0);
        end
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'h1234);
        check("mthi_lo", lo, '0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("both_hi", hi, 32'hABCD);
        check("both_lo", lo, 32'hABCD);

        // First start accepted on the edge after reset deasserts
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(2'b00, 32'd5, 32'd6);
        check("post_rst_busy", W'(busy), W'(1));
        waitDone();
        check("post_rst_latency", W'(cyc), W'(W));
        check("post_rst_lo", lo, 32'd30);
        check("post_rst_hi", hi, '0);

        // Register writes during RUN are dropped
        @(negedge clk);
        issue(2'b00, 32'd2, 32'd3);
        repeat (3) @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        check("busy_wr_hi", hi, '0);
        check("busy_wr_lo", lo, 32'd30);
        waitDone();
        check("busy_wr_res_lo", lo, 32'd6);
        check("busy_wr_res_hi", hi, '0);

        // Start and mthi on the same edge: start wins
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h77;
        @(negedge clk);
        check("pre_mthi", hi, 32'h77);
        wdata = 32'h5555;
        issue(2'b00, 32'd4, 32'd4);
        hi_we = 1'b0;
        check("race_hi", hi, 32'h77);
        waitDone();
        check("race_res_hi", hi, '0);
        check("race_res_lo", lo, 32'd16);

        // Back-to-back: start in DONE goes straight to RUN
        issue(2'b10, 32'd20, 32'd3);
        check("b2b_busy", W'(busy), W'(1));
        waitDone();
        check("b2b_latency", W'(cyc), W'(W));
        check("b2b_lo", lo, 32'd6);
        check("b2b_hi", hi, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
